vram_arbiter: RTL

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter_pkg.sv | 14 +
 rtl/rr_arb2.sv | 40 ++++
 rtl/vram_arbiter.sv | 93 +++++++++
 3 files changed

// File: rtl/vram_arbiter_pkg.sv
// Shared defaults and access-state encoding for the frame-memory arbiter.
package vram_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 15;
    localparam int unsigned DATA_W_DEF = 12;
    localparam int unsigned DROP_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DISP  = 2'b01,
        ST_WRITE = 2'b10
    } acc_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a registered preferred-writer pointer.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic rr_q;
    logic rr_d;

    always_comb begin
        gnt  = '0;
        rr_d = rr_q;
        if (en) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = rr_q ? 2'b10 : 2'b01;
                default: gnt = '0;
            endcase
        end
        // Pointer moves to the writer that was not just served.
        if (gnt[0]) begin
            rr_d = 1'b1;
        end else if (gnt[1]) begin
            rr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port frame-memory arbiter: display fetch has absolute priority,
// two writers share the remaining slots round-robin.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vblank,
    input  logic              cfg_vb_only,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_rvalid,
    input  logic [1:0]        wr_req,
    input  logic [ADDR_W-1:0] wr_addr0,
    input  logic [ADDR_W-1:0] wr_addr1,
    input  logic [DATA_W-1:0] wr_data0,
    input  logic [DATA_W-1:0] wr_data1,
    output logic [1:0]        wr_gnt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       wr_drop_cnt
);

    acc_state_e        state_q, state_d;
    logic [DROP_W-1:0] wr_drop_cnt_q, wr_drop_cnt_d;
    logic              wr_en;

    assign wr_en = rst_n && !disp_req && (!cfg_vb_only || vblank);

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (wr_en),
        .req   (wr_req),
        .gnt   (wr_gnt)
    );

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        state_d   = ST_IDLE;
        if (rst_n && disp_req) begin
            mem_en   = 1'b1;
            mem_addr = disp_addr;
            state_d  = ST_DISP;
        end else if (wr_gnt[0]) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = wr_addr0;
            mem_wdata = wr_data0;
            state_d   = ST_WRITE;
        end else if (wr_gnt[1]) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = wr_addr1;
            mem_wdata = wr_data1;
            state_d   = ST_WRITE;
        end
    end

    always_comb begin
        wr_drop_cnt_d = wr_drop_cnt_q;
        if ((wr_req != 2'b00) && (wr_gnt == 2'b00) && (wr_drop_cnt_q != '1)) begin
            wr_drop_cnt_d = wr_drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            wr_drop_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            wr_drop_cnt_q <= wr_drop_cnt_d;
        end
    end

    // Read data arrives one cycle after a DISP access; gating with rst_n
    // drops a fetch that is in flight when reset arrives.
    assign disp_rvalid = rst_n && (state_q == ST_DISP);
    assign disp_rdata  = disp_rvalid ? mem_rdata : '0;
    assign wr_drop_cnt = wr_drop_cnt_q;

endmodule
